sevenseg_scan: RTL
==================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is scanned (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load_valid  input  1  new display value offered.
REQ-005 SHALL have port load_value  input  16  four BCD nibbles; [15:12] is digit 3 (most significant), [3:0] is digit 0.
REQ-006 SHALL have port load_ready  output  1  block can accept a value this cycle.
REQ-007 SHALL have port anode_en  output  4  one-hot, active-high digit enable; bit n drives anode n.
REQ-008 SHALL have port seg  output  7  active-high segments; seg[0]=a through seg[6]=g.

Function
REQ-009 SHALL accept a value only in a cycle where load_valid and load_ready are both 1; load_value is ignored in all other cycles.
REQ-010 SHALL hold an accepted value in a pending register and set a pending flag; load_ready SHALL equal NOT pending.
REQ-011 SHALL run a prescaler counting 0..SCAN_DIV-1; the terminal count is a scan tick and the prescaler wraps to 0.
REQ-012 SHALL advance a 2-bit digit index on each scan tick: 0->1->2->3->0.
REQ-013 SHALL treat the scan tick on which the digit index wraps 3->0 as the frame boundary.
REQ-014 At a frame boundary with pending set, SHALL copy the pending register into the display register and clear pending.
REQ-015 If acceptance and a frame boundary coincide, SHALL write load_value directly into the display register and leave pending clear.
REQ-016 SHALL never change the display register other than at a frame boundary, so no frame shows mixed old and new digits.
REQ-017 SHALL drive anode_en and seg from registers, one cycle after the digit index and prescaler state they reflect.
REQ-018 SHALL drive anode_en=0000 and seg=0000000 for the first cycle (prescaler==0) of every digit slot, as an anti-ghosting blank.
REQ-019 For the remaining SCAN_DIV-1 cycles of a slot, SHALL drive anode_en with bit [digit index] set and seg with the decoded nibble.
REQ-020 SHALL decode nibbles as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, seg[6:0]).
REQ-021 SHALL decode nibbles A..F as a dash, 40 (segment g only).

Reset
REQ-022 While rst=1, SHALL hold: prescaler=0, digit index=0, display=0000, pending=0, load_ready=1, anode_en=0000, seg=0000000.
REQ-023 Reset asserted mid-frame or with a value pending SHALL discard the pending value; scanning SHALL restart at digit 0, slot cycle 0, after release.

Configuration
REQ-024 With macro LEADING_ZERO_BLANK_EN defined, SHALL force seg=0000000 for digits 3..1 that are zero and have only zero digits above them; digit 0 SHALL always be shown, and anode timing SHALL be unchanged.
REQ-025 Without LEADING_ZERO_BLANK_EN, SHALL decode every digit per REQ-020/REQ-021.

Verification (SCAN_DIV=4)
REQ-026 Release reset, no load -> each anode_en value 0001,0010,0100,1000 appears for 3 cycles after a 1-cycle blank; seg=3F (LEADING_ZERO_BLANK_EN off).
REQ-027 Load 16'h1234 mid-frame -> load_ready drops next cycle; the current frame still shows 0000; the next frame shows 66,4F,5B,06 on digits 0..3; load_ready returns to 1 at that boundary.
REQ-028 Second load while pending -> not accepted until the boundary; first value displayed; second accepted only after load_ready rises.
REQ-029 load_valid held high through a frame boundary with value 16'h8888 -> value visible in the frame starting at that boundary; pending stays 0.
REQ-030 Value 16'h00A7 -> digit0=07, digit1=40, digits 2,3=3F without the macro; digits 2,3 blank with LEADING_ZERO_BLANK_EN.
REQ-031 Assert rst during digit 2 with a value pending -> outputs zero immediately (asynchronous); after release, display=0000, load_ready=1, scanning restarts at digit 0.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous value updates.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module sevenseg_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_value,
    output logic        load_ready,
    output logic [3:0]  anode_en,
    output logic [6:0]  seg
);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q, pend_d;
    logic        pending_q, pending_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;

    logic        tick;
    logic        frame;
    logic        accept;
    logic [3:0]  nibble;
    logic        hide;
    logic [3:0]  lz;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign load_ready = ~pending_q;
    assign anode_en   = anode_q;
    assign seg        = seg_q;

    assign tick   = (presc_q == 16'(SCAN_DIV - 1));
    assign frame  = tick && (digit_q == 2'd3);
    assign accept = load_valid && ~pending_q;
    assign nibble = disp_q[{digit_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // lz[n]: digit n and every digit above it are zero; digit 0 is never hidden.
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (disp_q[15:12] == 4'd0);
        lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
        lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    end
`else
    assign lz = 4'b0000;
`endif
    assign hide = lz[digit_q];

    always_comb begin
        presc_d   = tick ? 16'd0 : presc_q + 16'd1;
        digit_d   = tick ? digit_q + 2'd1 : digit_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        // The display register only ever moves on a frame boundary, so a frame is never mixed.
        if (frame) begin
            pending_d = 1'b0;
            if (accept)
                disp_d = load_value;
            else if (pending_q)
                disp_d = pend_q;
        end else if (accept) begin
            pend_d    = load_value;
            pending_d = 1'b1;
        end
        if (presc_q == 16'd0) begin
            anode_d = 4'b0000;
            seg_d   = 7'b0000000;
        end else begin
            anode_d = 4'b0001 << digit_q;
            seg_d   = hide ? 7'b0000000 : decode(nibble);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= 16'd0;
            digit_q   <= 2'd0;
            disp_q    <= 16'd0;
            pend_q    <= 16'd0;
            pending_q <= 1'b0;
            anode_q   <= 4'b0000;
            seg_q     <= 7'b0000000;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

endmodule
